// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - opcode/memory-ready inputs and datapath control outputs of the multi-cycle control unit
interface multicycle_control_if #(
    parameter int ALUOP_W = 3,
    parameter int COUNT_W = 32
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_source;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic [1:0]         reg_dst;
    logic               reg_write;
    logic               link_sel;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               imm_zext;
    logic               illegal;
    logic [COUNT_W-1:0] retired;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, link_sel, alu_src_a,
               alu_src_b, alu_op, imm_zext, illegal, retired
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, link_sel, alu_src_a,
               alu_src_b, alu_op, imm_zext, illegal, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with memory timeout, illegal trap and retired counter
module multicycle_control #(
    parameter int ALUOP_W     = 3,
    parameter int COUNT_W     = 32,
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    // Last wait count still tolerated; a low mem_ready at this count traps.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_TRAP
    } state_t;

    state_t               state, state_next;
    logic [5:0]           op_q;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [COUNT_W-1:0]   retired_q;
    logic                 mem_wait;
    logic                 timeout_hit;

    function automatic logic [ALUOP_W-1:0] i_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: i_alu_op = ALUOP_W'(3'b011);
            OP_ORI:  i_alu_op = ALUOP_W'(3'b100);
            OP_SLTI: i_alu_op = ALUOP_W'(3'b101);
            OP_LUI:  i_alu_op = ALUOP_W'(3'b110);
            default: i_alu_op = ALUOP_W'(3'b000);
        endcase
    endfunction

    assign mem_wait    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && !bus.mem_ready && (wait_cnt == WAIT_LAST);
    assign bus.retired = retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            wait_cnt  <= '0;
            retired_q <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) op_q <= bus.opcode;
            if (state_next != state)
                wait_cnt <= '0;
            else if (mem_wait && !bus.mem_ready)
                wait_cnt <= wait_cnt + TIMEOUT_W'(1);
            if (state_next == S_FETCH && state != S_FETCH && state != S_IDLE)
                retired_q <= retired_q + COUNT_W'(1);
        end
    end

    always_comb begin
        state_next        = state;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 2'b00;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 2'b00;
        bus.reg_write     = 1'b0;
        bus.link_sel      = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = '0;
        bus.imm_zext      = 1'b0;
        bus.illegal       = 1'b0;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                // IR load and PC+4 happen in the same cycle the memory delivers.
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready)  state_next = S_DECODE;
                else if (timeout_hit) state_next = S_TRAP;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_R:                               state_next = S_R_EXEC;
                    OP_LW, OP_SW:                       state_next = S_MEM_ADDR;
                    OP_BEQ:                             state_next = S_BRANCH;
                    OP_J:                               state_next = S_JUMP;
                    OP_JAL:                             state_next = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI,
                    OP_LUI:                             state_next = S_I_EXEC;
                    default:                            state_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_next    = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready)    state_next = S_MEM_WB;
                else if (timeout_hit) state_next = S_TRAP;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready)    state_next = S_FETCH;
                else if (timeout_hit) state_next = S_TRAP;
            end
            S_R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_W'(3'b010);
                state_next    = S_R_WB;
            end
            S_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 2'b01;
                state_next    = S_FETCH;
            end
            S_I_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = i_alu_op(op_q);
                bus.imm_zext  = (op_q == OP_ANDI) || (op_q == OP_ORI);
                state_next    = S_I_WB;
            end
            S_I_WB: begin
                bus.reg_write = 1'b1;
                bus.alu_op    = i_alu_op(op_q);
                bus.imm_zext  = (op_q == OP_ANDI) || (op_q == OP_ORI);
                state_next    = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALUOP_W'(3'b001);
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
                state_next        = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
                state_next    = S_FETCH;
            end
            S_JAL: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
                bus.reg_write = 1'b1;
                bus.reg_dst   = 2'b10;
                bus.link_sel  = 1'b1;
                state_next    = S_FETCH;
            end
            S_TRAP:  bus.illegal = 1'b1;
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized instruction-level checking of multicycle_control
module tb_multicycle_control;
    localparam int TMO = 4;
    localparam int CW  = 2;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       link_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       imm_zext;
        logic       illegal;
    } ctl_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if #(.ALUOP_W(3), .COUNT_W(CW)) bus ();

    multicycle_control #(
        .ALUOP_W(3), .COUNT_W(CW), .TIMEOUT_W(8), .MEM_TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec     = 0;
    int n_err     = 0;
    int retired_m = 0;
    int fetch_fix = -1;
    int mem_fix   = -1;
    int trap_len  = 3;
    logic [5:0] legal [11] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL,
                               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ctl_t observed();
        ctl_t o;
        o.pc_write      = bus.pc_write;
        o.pc_write_cond = bus.pc_write_cond;
        o.pc_source     = bus.pc_source;
        o.iord          = bus.iord;
        o.mem_read      = bus.mem_read;
        o.mem_write     = bus.mem_write;
        o.ir_write      = bus.ir_write;
        o.mem_to_reg    = bus.mem_to_reg;
        o.reg_dst       = bus.reg_dst;
        o.reg_write     = bus.reg_write;
        o.link_sel      = bus.link_sel;
        o.alu_src_a     = bus.alu_src_a;
        o.alu_src_b     = bus.alu_src_b;
        o.alu_op        = bus.alu_op;
        o.imm_zext      = bus.imm_zext;
        o.illegal       = bus.illegal;
        return o;
    endfunction

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    function automatic int pick_delay(input int fix);
        if (fix >= 0) return fix;
        if ($urandom_range(0, 19) < 17) return int'($urandom_range(0, 3));
        return int'($urandom_range(4, 6));
    endfunction

    // Instruction class: 0 R, 1 lw, 2 sw, 3 beq, 4 j, 5 jal, 6 I-alu, -1 illegal.
    function automatic int classify(input logic [5:0] op);
        case (op)
            OP_R:   return 0;
            OP_LW:  return 1;
            OP_SW:  return 2;
            OP_BEQ: return 3;
            OP_J:   return 4;
            OP_JAL: return 5;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: return 6;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu(input logic [5:0] op);
        case (op)
            OP_ANDI: return 3'b011;
            OP_ORI:  return 3'b100;
            OP_SLTI: return 3'b101;
            OP_LUI:  return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    // One clock slot: called just after a rising edge, checks at the falling edge.
    task automatic step(input string tag, input ctl_t e, input logic rdy,
                        input logic [5:0] op, input int exp_ret);
        #1;
        bus.mem_ready = rdy;
        bus.opcode    = op;
        @(negedge clk);
        chk(tag, {43'd0, observed()}, {43'd0, e});
        if (exp_ret >= 0) chk("retired", 64'(bus.retired), 64'(exp_ret));
        @(posedge clk);
    endtask

    task automatic apply_reset();
        #1;
        bus.mem_ready = 1'($urandom);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {43'd0, observed()}, 64'd0);
        chk("rst_retired", 64'(bus.retired), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle", {43'd0, observed()}, 64'd0);
        @(posedge clk);
        retired_m = 0;
    endtask

    task automatic trap_then_reset();
        ctl_t e;
        e = '0;
        e.illegal = 1'b1;
        for (int i = 0; i < trap_len; i++) step("trap", e, 1'($urandom), junk(), -1);
        apply_reset();
    endtask

    task automatic mem_phase(input logic is_wr, input bit abort, output bit trapped);
        ctl_t e;
        int d;
        trapped = 1'b0;
        e = '0;
        e.iord      = 1'b1;
        e.mem_read  = !is_wr;
        e.mem_write = is_wr;
        d = pick_delay(mem_fix);
        for (int k = 0; k < 64; k++) begin
            if (abort && k == 2) begin
                apply_reset();
                trapped = 1'b1;
                return;
            end
            step(is_wr ? "mem_wr" : "mem_rd", e, k == d, junk(), -1);
            if (k == d) return;
            if (k == TMO - 1) begin
                trap_then_reset();
                trapped = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input bit abort);
        ctl_t e;
        int   d;
        int   cls;
        bit   trapped;
        d = pick_delay(fetch_fix);
        for (int k = 0; k < 64; k++) begin
            e = '0;
            e.mem_read  = 1'b1;
            e.alu_src_b = 2'b01;
            e.pc_write  = (k == d);
            e.ir_write  = (k == d);
            step("fetch", e, k == d, junk(), (k == 0) ? retired_m : -1);
            if (k == d) break;
            if (k == TMO - 1) begin
                trap_then_reset();
                return;
            end
        end
        e = '0;
        e.alu_src_b = 2'b11;
        step("decode", e, 1'($urandom), op, -1);
        cls = classify(op);
        if (cls < 0) begin
            trap_then_reset();
            return;
        end
        e = '0;
        case (cls)
            0: begin
                e.alu_src_a = 1'b1;
                e.alu_op    = 3'b010;
                step("r_exec", e, 1'($urandom), junk(), -1);
                e = '0;
                e.reg_write = 1'b1;
                e.reg_dst   = 2'b01;
                step("r_wb", e, 1'($urandom), junk(), -1);
            end
            1, 2: begin
                e.alu_src_a = 1'b1;
                e.alu_src_b = 2'b10;
                step("mem_addr", e, 1'($urandom), junk(), -1);
                mem_phase(cls == 2, abort, trapped);
                if (trapped) return;
                if (cls == 1) begin
                    e = '0;
                    e.reg_write  = 1'b1;
                    e.mem_to_reg = 1'b1;
                    step("mem_wb", e, 1'($urandom), junk(), -1);
                end
            end
            3: begin
                e.alu_src_a     = 1'b1;
                e.alu_op        = 3'b001;
                e.pc_write_cond = 1'b1;
                e.pc_source     = 2'b01;
                step("branch", e, 1'($urandom), junk(), -1);
            end
            4, 5: begin
                e.pc_write  = 1'b1;
                e.pc_source = 2'b10;
                e.reg_write = (cls == 5);
                e.reg_dst   = (cls == 5) ? 2'b10 : 2'b00;
                e.link_sel  = (cls == 5);
                step(cls == 5 ? "jal" : "jump", e, 1'($urandom), junk(), -1);
            end
            default: begin
                e.alu_src_a = 1'b1;
                e.alu_src_b = 2'b10;
                e.alu_op    = imm_alu(op);
                e.imm_zext  = (op == OP_ANDI) || (op == OP_ORI);
                step("i_exec", e, 1'($urandom), junk(), -1);
                e.alu_src_a = 1'b0;
                e.alu_src_b = 2'b00;
                e.reg_write = 1'b1;
                step("i_wb", e, 1'($urandom), junk(), -1);
            end
        endcase
        retired_m = (retired_m + 1) % (1 << CW);
    endtask

    initial begin
        logic [5:0] op;
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        apply_reset();

        fetch_fix = 0;
        mem_fix   = 0;
        run_instr(OP_R, 1'b0);
        mem_fix = 3;
        run_instr(OP_LW, 1'b0);
        mem_fix = 0;
        run_instr(OP_ANDI, 1'b0);
        run_instr(OP_LUI, 1'b0);
        run_instr(OP_JAL, 1'b0);
        run_instr(OP_BEQ, 1'b0);
        trap_len = 20;
        run_instr(6'b111111, 1'b0);
        trap_len = 3;
        fetch_fix = 10;
        run_instr(OP_R, 1'b0);
        fetch_fix = 0;
        repeat (5) run_instr(OP_R, 1'b0);
        mem_fix = 10;
        run_instr(OP_SW, 1'b0);
        run_instr(OP_SW, 1'b1);
        fetch_fix = -1;
        mem_fix   = -1;

        repeat (300) begin
            if ($urandom_range(0, 9) < 8) op = legal[$urandom_range(0, 10)];
            else op = junk();
            trap_len = int'($urandom_range(2, 5));
            run_instr(op, 1'b0);
        end
        #1;
        @(negedge clk);
        chk("retired_end", 64'(bus.retired), 64'(retired_m));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parametrised multi-cycle MIPS control unit, the next generation of the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. Memory accesses use a ready handshake, and the block adds a memory timeout, a sticky illegal-opcode trap and a retired-instruction counter. It sits between the instruction register (opcode source) and the multi-cycle datapath muxes, register file and memory port.

Parameters:
ALUOP_W, 3, width of alu_op; minimum 3.
COUNT_W, 32, width of retired-instruction counter.
TIMEOUT_W, 8, width of memory wait counter.
MEM_TIMEOUT, 255, max wait cycles for mem_ready; 0 disables timeout.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  async active-low reset
opcode  in  6  IR[31:26]; valid from DECODE onward
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
iord  out  1  0 memory address=PC, 1 address=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load IR
mem_to_reg  out  1  writeback data from MDR
reg_dst  out  2  00 rt, 01 rd, 10 $31
reg_write  out  1  register file write
link_sel  out  1  writeback data = PC (jal)
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  00 rt, 01 const 4, 10 sign/zero-ext imm, 11 imm<<2
alu_op  out  ALUOP_W  000 ADD, 001 SUB, 010 FUNCT, 011 AND, 100 OR, 101 SLT, 110 LUI
imm_zext  out  1  zero-extend immediate (andi/ori)
illegal  out  1  sticky trap: bad opcode or memory timeout
retired  out  COUNT_W  count of completed instructions

Behaviour:
- Async reset: state=IDLE, op_q=0, wait counter=0, retired=0, illegal=0. Every output is 0 during reset and in IDLE.
- State, op_q and counters are registered. Outputs are decoded from state/op_q. Exception: in FETCH, ir_write and pc_write equal mem_ready, combinationally.
- IDLE: advance to FETCH unconditionally.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00. Hold until mem_ready, then go to DECODE.
- DECODE: latch opcode into op_q. alu_src_a=0, alu_src_b=11, alu_op=ADD. Dispatch on opcode:
  - 000000 to R_EXEC
  - 100011/101011 to MEM_ADDR
  - 000100 to BRANCH
  - 000010 to JUMP
  - 000011 to JAL
  - 001000/001100/001101/001010/001111 to I_EXEC
  - anything else to TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Go to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, iord=1. On mem_ready go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=00, then FETCH.
- MEM_WR: mem_write=1, iord=1. On mem_ready go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, FUNCT, then R_WB. R_WB: reg_write=1, reg_dst=01, then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. alu_op: addi ADD, andi AND, ori OR, slti SLT, lui LUI. imm_zext=1 for andi/ori. Then I_WB.
- I_WB: reg_write=1, reg_dst=00; alu_op and imm_zext held from I_EXEC. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01, then FETCH.
- JUMP: pc_write=1, pc_source=10, then FETCH.
- JAL: as JUMP, plus reg_write=1, reg_dst=10, link_sel=1, then FETCH.
- TRAP: illegal=1, all other outputs 0. Exit only by reset.
- Wait counter: clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle mem_ready is low there. If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready still low, go to TRAP next cycle. mem_ready high in that same cycle wins (normal transition).
- retired: +1 on every transition into FETCH from a non-IDLE state. Wraps modulo 2^COUNT_W. TRAP does not count.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Reset asserted mid-instruction: immediate return to IDLE, with no partial write or PC update.

Test Plan:
- Reset, then mem_ready=1 always, opcode=000000 → IDLE, FETCH (pc_write=ir_write=1), DECODE, R_EXEC (alu_op=010), R_WB (reg_write=1, reg_dst=01), FETCH; retired=1.
- lw (100011) with mem_ready delayed 3 cycles in MEM_RD → MEM_RD held 4 cycles with mem_read=1, iord=1; MEM_WB has mem_to_reg=1; retired increments once.
- andi (001100) then lui (001111) → I_EXEC alu_op 011 with imm_zext=1, then alu_op 110 with imm_zext=0; reg_dst=00 in I_WB.
- jal (000011) → JAL cycle with pc_write=1, pc_source=10, reg_write=1, reg_dst=10, link_sel=1. beq → pc_write_cond=1, alu_op=001.
- opcode=111111 → TRAP, illegal=1 held 20 cycles; rst_n low clears it. MEM_TIMEOUT=4 with mem_ready stuck low in FETCH → TRAP after 4 wait cycles.
- COUNT_W=2, 5 R-type instructions → retired goes 1,2,3,0,1. rst_n pulse during MEM_WR → all outputs 0 and state IDLE immediately.
